// File: rtl/sgpr_wr_arbiter_pkg.sv
// sgpr_pkg: shared SGPR write-port constants.
package sgpr_pkg;
    localparam int SGPR_WR_SEL_W     = 16;
    localparam int NUM_SGPR_WR_PORTS = 10;
    localparam int SALU_WR_PORT      = 9;
endpackage

// File: rtl/sgpr_wr_arbiter_if.sv
// sgpr_wr_arbiter_if: request/grant bundle between SGPR writers and the write arbiter.
interface sgpr_wr_arbiter_if
    import sgpr_pkg::*;
#(
    parameter int NUM_PORTS = NUM_SGPR_WR_PORTS
) ();
    logic [NUM_PORTS-1:0]     req;
    logic [NUM_PORTS-1:0]     grant;
    logic [SGPR_WR_SEL_W-1:0] wr_port_select;
    logic [NUM_PORTS-1:0]     urgent;
    modport master (output req, input grant, wr_port_select, urgent);
    modport slave  (input req, output grant, wr_port_select, urgent);
endinterface

// File: rtl/sgpr_wr_arbiter_rr_pick_onehot.sv
// rr_pick_onehot: first set bit of i_mask scanning circularly from i_ptr, as a one-hot.
module rr_pick_onehot #(
    parameter int N  = 10,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_mask,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_win
);
    logic [PW:0] w_idx;
    logic        w_found;
    always_comb begin
        o_win   = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = 0; k < N; k++) begin
            w_idx = {1'b0, i_ptr} + (PW+1)'(k);
            if (w_idx >= (PW+1)'(N)) w_idx = w_idx - (PW+1)'(N);
            if (!w_found && i_mask[w_idx[PW-1:0]]) begin
                o_win[w_idx[PW-1:0]] = 1'b1;
                w_found              = 1'b1;
            end
        end
    end
endmodule

// File: rtl/sgpr_wr_arbiter.sv
// sgpr_wr_arbiter: registered round-robin SGPR write arbiter with strict-priority
// ports and an age-based starvation guard.
module sgpr_wr_arbiter
    import sgpr_pkg::*;
#(
    parameter int                   NUM_PORTS = NUM_SGPR_WR_PORTS,
    parameter logic [NUM_PORTS-1:0] PRIO_MASK = NUM_PORTS'(1 << SALU_WR_PORT),
    parameter int                   MAX_WAIT  = 8
) (
    input  logic               clk,
    input  logic               rst,
    sgpr_wr_arbiter_if.slave   bus
);
    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int CW = $clog2(MAX_WAIT + 1);
    logic [NUM_PORTS-1:0]         r_grant;
    logic [NUM_PORTS-1:0]         r_urgent;
    logic [PW-1:0]                r_ptr;
    logic [NUM_PORTS-1:0][CW-1:0] r_wait_cnt;
    logic [NUM_PORTS-1:0]         w_elig;
    logic [NUM_PORTS-1:0]         w_win_urg;
    logic [NUM_PORTS-1:0]         w_win_prio;
    logic [NUM_PORTS-1:0]         w_win_any;
    logic [NUM_PORTS-1:0]         w_win;
    logic [PW-1:0]                w_win_idx;
    logic [PW-1:0]                w_ptr_nxt;
    logic [NUM_PORTS-1:0][CW-1:0] w_cnt_nxt;
    logic [NUM_PORTS-1:0]         w_urg_nxt;
    // The port granted last cycle still shows the request being consumed.
    assign w_elig = bus.req & ~r_grant;
    rr_pick_onehot #(.N(NUM_PORTS), .PW(PW)) u_pick_urg (
        .i_mask(w_elig & r_urgent), .i_ptr(r_ptr), .o_win(w_win_urg));
    rr_pick_onehot #(.N(NUM_PORTS), .PW(PW)) u_pick_prio (
        .i_mask(w_elig & PRIO_MASK), .i_ptr(r_ptr), .o_win(w_win_prio));
    rr_pick_onehot #(.N(NUM_PORTS), .PW(PW)) u_pick_any (
        .i_mask(w_elig), .i_ptr(r_ptr), .o_win(w_win_any));
    assign w_win = |(w_elig & r_urgent)  ? w_win_urg  :
                   |(w_elig & PRIO_MASK) ? w_win_prio : w_win_any;
    always_comb begin
        w_win_idx = '0;
        for (int i = 0; i < NUM_PORTS; i++)
            if (w_win[i]) w_win_idx = PW'(i);
        w_ptr_nxt = (w_win_idx == PW'(NUM_PORTS - 1)) ? '0 : w_win_idx + PW'(1);
    end
    always_comb begin
        w_cnt_nxt = r_wait_cnt;
        w_urg_nxt = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_cnt_nxt[i] = (!bus.req[i] || w_win[i]) ? '0 :
                           (w_elig[i] && r_wait_cnt[i] != CW'(MAX_WAIT)) ? r_wait_cnt[i] + CW'(1) :
                           r_wait_cnt[i];
            w_urg_nxt[i] = (w_cnt_nxt[i] == CW'(MAX_WAIT));
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant    <= '0;
            r_urgent   <= '0;
            r_ptr      <= '0;
            r_wait_cnt <= '0;
        end else begin
            r_grant    <= w_win;
            r_urgent   <= w_urg_nxt;
            r_wait_cnt <= w_cnt_nxt;
            if (|w_win) r_ptr <= w_ptr_nxt;
        end
    end
    assign bus.grant          = r_grant;
    assign bus.urgent         = r_urgent;
    assign bus.wr_port_select = SGPR_WR_SEL_W'(r_grant);
    a_grant_onehot: assert property (@(posedge clk) $onehot0(r_grant));
endmodule

// File: tb/tb_sgpr_wr_arbiter.sv
// tb_sgpr_wr_arbiter: directed checks of the SGPR write arbiter in three parameter setups.
module tb_sgpr_wr_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    always #5 clk = ~clk;
    sgpr_wr_arbiter_if #(.NUM_PORTS(10)) ia ();
    sgpr_wr_arbiter_if #(.NUM_PORTS(10)) ib ();
    sgpr_wr_arbiter_if #(.NUM_PORTS(10)) ic ();
    sgpr_wr_arbiter #(.NUM_PORTS(10), .PRIO_MASK(10'h200), .MAX_WAIT(8)) dut_a (.clk(clk), .rst(rst), .bus(ia));
    sgpr_wr_arbiter #(.NUM_PORTS(10), .PRIO_MASK(10'h000), .MAX_WAIT(8)) dut_b (.clk(clk), .rst(rst), .bus(ib));
    sgpr_wr_arbiter #(.NUM_PORTS(10), .PRIO_MASK(10'h300), .MAX_WAIT(4)) dut_c (.clk(clk), .rst(rst), .bus(ic));
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic do_reset();
        ia.req = '0;
        ib.req = '0;
        ic.req = '0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask
    task automatic test_reset();
        rst = 1'b1;
        ia.req = 10'h3ff;
        ib.req = '0;
        ic.req = '0;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_tests++;
            if (ia.wr_port_select !== 16'h0000 || ia.grant !== 10'h000 || ia.urgent !== 10'h000) begin
                n_fail++;
                $display("FAIL reset_hold[%0d]: select=%h grant=%h urgent=%h, want 0000/000/000",
                         k, ia.wr_port_select, ia.grant, ia.urgent);
            end
        end
        rst = 1'b0;
        tick();
        n_tests++;
        if (ia.wr_port_select !== 16'h0200) begin
            n_fail++;
            $display("FAIL reset_first_grant: select=%h want 0200", ia.wr_port_select);
        end
        ia.req = '0;
    endtask
    task automatic test_single();
        logic [15:0] exp [5] = '{16'h0008, 16'h0000, 16'h0008, 16'h0000, 16'h0000};
        do_reset();
        ia.req = 10'h008;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (k == 2) ia.req = '0;
            n_tests++;
            if (ia.wr_port_select !== exp[k]) begin
                n_fail++;
                $display("FAIL single[%0d]: select=%h want %h", k, ia.wr_port_select, exp[k]);
            end
        end
    endtask
    task automatic test_rotation();
        logic [15:0] want;
        do_reset();
        ib.req = 10'h3ff;
        for (int k = 0; k < 11; k++) begin
            tick();
            want = 16'h0001 << (k % 10);
            n_tests++;
            if (ib.wr_port_select !== want || !$onehot(ib.grant)) begin
                n_fail++;
                $display("FAIL rotation[%0d]: select=%h grant=%h want %h", k, ib.wr_port_select, ib.grant, want);
            end
        end
        ib.req = '0;
    endtask
    task automatic test_priority();
        logic [15:0] want;
        do_reset();
        ia.req = 10'h201;
        for (int k = 0; k < 6; k++) begin
            tick();
            want = (k % 2 == 0) ? 16'h0200 : 16'h0001;
            n_tests++;
            if (ia.wr_port_select !== want) begin
                n_fail++;
                $display("FAIL priority[%0d]: select=%h want %h", k, ia.wr_port_select, want);
            end
        end
        ia.req = '0;
    endtask
    task automatic test_starvation();
        logic [15:0] exp [11] = '{16'h0100, 16'h0200, 16'h0100, 16'h0200, 16'h0001, 16'h0100,
                                  16'h0200, 16'h0100, 16'h0200, 16'h0100, 16'h0001};
        logic [9:0]  urg [11] = '{10'h000, 10'h000, 10'h000, 10'h001, 10'h000, 10'h000,
                                  10'h000, 10'h000, 10'h000, 10'h001, 10'h000};
        do_reset();
        ic.req = 10'h301;
        for (int k = 0; k < 11; k++) begin
            tick();
            n_tests++;
            if (ic.wr_port_select !== exp[k] || ic.urgent !== urg[k]) begin
                n_fail++;
                $display("FAIL starvation[%0d]: select=%h urgent=%h want %h/%h",
                         k, ic.wr_port_select, ic.urgent, exp[k], urg[k]);
            end
        end
        ic.req = '0;
    endtask
    task automatic test_withdrawal();
        logic [3:0]  cexp [3] = '{4'd1, 4'd2, 4'd0};
        logic [15:0] sexp [3] = '{16'h0200, 16'h0001, 16'h0200};
        do_reset();
        ia.req = 10'h221;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (k == 1) ia.req = 10'h201;
            n_tests++;
            if (ia.wr_port_select !== sexp[k] || dut_a.r_wait_cnt[5] !== cexp[k]) begin
                n_fail++;
                $display("FAIL withdrawal[%0d]: select=%h wait5=%0d want %h/%0d",
                         k, ia.wr_port_select, dut_a.r_wait_cnt[5], sexp[k], cexp[k]);
            end
        end
        for (int k = 0; k < 10; k++) begin
            tick();
            n_tests++;
            if (ia.grant[5] !== 1'b0 || !$onehot(ia.grant)) begin
                n_fail++;
                $display("FAIL withdrawal_no_grant5[%0d]: grant=%h want bit5=0 one-hot", k, ia.grant);
            end
        end
        ia.req = '0;
    endtask
    initial begin
        ia.req = '0;
        ib.req = '0;
        ic.req = '0;
        test_reset();
        test_single();
        test_rotation();
        test_priority();
        test_starvation();
        test_withdrawal();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
